zero_seq_injector: RTL and testbench

//  Min-max zero-sequence injection stage of the SVPWM modulating-signal generator.

---
 rtl/zero_seq_injector_if.sv | 29 ++
 rtl/zero_seq_injector.sv | 147 ++++++++++++++
 tb/tb_zero_seq_injector.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zero_seq_injector_if.sv
// rtl/zero_seq_injector_if.sv - phase-in / modulating-signal-out bundle of the zero-sequence injector
interface zero_seq_injector_if #(
  parameter int DW       = 16,
  parameter int SATCNT_W = 16
);
  logic                clk_enable;
  logic                in_valid;
  logic signed [DW-1:0] in_a;
  logic signed [DW-1:0] in_b;
  logic signed [DW-1:0] in_c;
  logic                sat_clr;
  logic                out_valid;
  logic signed [DW-1:0] out_a;
  logic signed [DW-1:0] out_b;
  logic signed [DW-1:0] out_c;
  logic                sat_flag;
  logic [SATCNT_W-1:0] sat_count;
  logic                ce_out;

  modport master (
    output clk_enable, in_valid, in_a, in_b, in_c, sat_clr,
    input  out_valid, out_a, out_b, out_c, sat_flag, sat_count, ce_out
  );

  modport slave (
    input  clk_enable, in_valid, in_a, in_b, in_c, sat_clr,
    output out_valid, out_a, out_b, out_c, sat_flag, sat_count, ce_out
  );
endinterface

// File: rtl/zero_seq_injector.sv
// rtl/zero_seq_injector.sv - min-max zero-sequence injection pipeline for SVPWM
// Four enabled-edge stages: capture, max/min, offset, add-and-clip.
module zero_seq_injector #(
  parameter int DW       = 16,
  parameter int SATCNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  zero_seq_injector_if.slave bus
);

  localparam logic signed [DW+1:0] LIM_HI  = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] LIM_LO  = {3'b111, {(DW-1){1'b0}}};
  localparam logic [SATCNT_W-1:0]  CNT_MAX = '1;
  localparam logic [SATCNT_W-1:0]  CNT_ONE = {{(SATCNT_W-1){1'b0}}, 1'b1};

  logic                 r_s1_valid;
  logic signed [DW-1:0] r_s1_a, r_s1_b, r_s1_c;

  logic                 r_s2_valid;
  logic signed [DW-1:0] r_s2_a, r_s2_b, r_s2_c;
  logic signed [DW-1:0] r_s2_max, r_s2_min;

  logic                 r_s3_valid;
  logic signed [DW-1:0] r_s3_a, r_s3_b, r_s3_c;
  logic signed [DW:0]   r_s3_off;

  logic                 r_out_valid;
  logic signed [DW-1:0] r_out_a, r_out_b, r_out_c;
  logic                 r_sat_flag;
  logic [SATCNT_W-1:0]  r_sat_count;

  logic signed [DW-1:0] w_max_ab, w_max, w_min_ab, w_min;
  logic signed [DW:0]   w_sum, w_half, w_off;
  logic signed [DW+1:0] w_y_a, w_y_b, w_y_c;
  logic                 w_clip_a, w_clip_b, w_clip_c, w_clip_any;

  function automatic logic signed [DW-1:0] f_clip(input logic signed [DW+1:0] y);
    if (y > LIM_HI) begin
      f_clip = LIM_HI[DW-1:0];
    end else if (y < LIM_LO) begin
      f_clip = LIM_LO[DW-1:0];
    end else begin
      f_clip = y[DW-1:0];
    end
  endfunction

  // On ties the earlier operand wins; both candidates are equal so the result is unaffected.
  assign w_max_ab = (r_s1_a >= r_s1_b) ? r_s1_a : r_s1_b;
  assign w_max    = (w_max_ab >= r_s1_c) ? w_max_ab : r_s1_c;
  assign w_min_ab = (r_s1_a <= r_s1_b) ? r_s1_a : r_s1_b;
  assign w_min    = (w_min_ab <= r_s1_c) ? w_min_ab : r_s1_c;

  // Arithmetic shift floors the half-sum, so the negated offset always fits DW+1 bits.
  assign w_sum  = {r_s2_max[DW-1], r_s2_max} + {r_s2_min[DW-1], r_s2_min};
  assign w_half = w_sum >>> 1;
  assign w_off  = -w_half;

  assign w_y_a = {{2{r_s3_a[DW-1]}}, r_s3_a} + {r_s3_off[DW], r_s3_off};
  assign w_y_b = {{2{r_s3_b[DW-1]}}, r_s3_b} + {r_s3_off[DW], r_s3_off};
  assign w_y_c = {{2{r_s3_c[DW-1]}}, r_s3_c} + {r_s3_off[DW], r_s3_off};

  assign w_clip_a   = (w_y_a > LIM_HI) || (w_y_a < LIM_LO);
  assign w_clip_b   = (w_y_b > LIM_HI) || (w_y_b < LIM_LO);
  assign w_clip_c   = (w_y_c > LIM_HI) || (w_y_c < LIM_LO);
  assign w_clip_any = w_clip_a || w_clip_b || w_clip_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_c      <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_a      <= '0;
      r_s2_b      <= '0;
      r_s2_c      <= '0;
      r_s2_max    <= '0;
      r_s2_min    <= '0;
      r_s3_valid  <= 1'b0;
      r_s3_a      <= '0;
      r_s3_b      <= '0;
      r_s3_c      <= '0;
      r_s3_off    <= '0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_c     <= '0;
      r_sat_flag  <= 1'b0;
    end else if (bus.clk_enable) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_a <= bus.in_a;
        r_s1_b <= bus.in_b;
        r_s1_c <= bus.in_c;
      end

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_a   <= r_s1_a;
        r_s2_b   <= r_s1_b;
        r_s2_c   <= r_s1_c;
        r_s2_max <= w_max;
        r_s2_min <= w_min;
      end

      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_a   <= r_s2_a;
        r_s3_b   <= r_s2_b;
        r_s3_c   <= r_s2_c;
        r_s3_off <= w_off;
      end

      // Outputs and the clip flag hold their last sample through valid gaps.
      r_out_valid <= r_s3_valid;
      if (r_s3_valid) begin
        r_out_a    <= f_clip(w_y_a);
        r_out_b    <= f_clip(w_y_b);
        r_out_c    <= f_clip(w_y_c);
        r_sat_flag <= w_clip_any;
      end
    end
  end

  // Counts in step with the output register that carries the clipped sample; clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sat_count <= '0;
    end else if (bus.clk_enable) begin
      if (bus.sat_clr) begin
        r_sat_count <= '0;
      end else if (r_s3_valid && w_clip_any && (r_sat_count != CNT_MAX)) begin
        r_sat_count <= r_sat_count + CNT_ONE;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_c     = r_out_c;
  assign bus.sat_flag  = r_sat_flag;
  assign bus.sat_count = r_sat_count;
  assign bus.ce_out    = bus.clk_enable;

endmodule

// File: tb/tb_zero_seq_injector.sv
// tb/tb_zero_seq_injector.sv - randomized self-checking bench for zero_seq_injector
module tb_zero_seq_injector;
  localparam int DW = 16;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  zero_seq_injector_if #(.DW(DW), .SATCNT_W(SW)) bus ();
  zero_seq_injector #(.DW(DW), .SATCNT_W(SW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    int a;
    int b;
    int c;
    int due;
  } item_t;

  item_t q[$];
  int    e_cnt;
  bit    exp_valid, exp_flag, drv_ce;
  int    exp_a, exp_b, exp_c, exp_cnt;
  int    checks, failures;

  // Reference: offset = -floor((max+min)/2), added to each phase, clamped to int16.
  function automatic void ref_calc(input int a, input int b, input int c,
                                   output int ya, output int yb, output int yc, output bit flag);
    int x[3];
    int y[3];
    int mx, mn, s, off;
    x[0] = a; x[1] = b; x[2] = c;
    mx = a; mn = a;
    for (int i = 1; i < 3; i++) begin
      if (x[i] > mx) mx = x[i];
      if (x[i] < mn) mn = x[i];
    end
    s = mx + mn;
    off = (s >= 0) ? -(s / 2) : -((s - 1) / 2);
    flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      y[i] = x[i] + off;
      if (y[i] > 32767) begin y[i] = 32767; flag = 1'b1; end
      else if (y[i] < -32768) begin y[i] = -32768; flag = 1'b1; end
    end
    ya = y[0]; yb = y[1]; yc = y[2];
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic logic [66:0] got_vec();
    return {bus.out_valid, bus.out_a, bus.out_b, bus.out_c, bus.sat_flag, bus.sat_count, bus.ce_out};
  endfunction

  function automatic logic [66:0] exp_vec();
    return {exp_valid, 16'(exp_a), 16'(exp_b), 16'(exp_c), exp_flag, 16'(exp_cnt), drv_ce};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_valid = 0; exp_flag = 0;
    exp_a = 0; exp_b = 0; exp_c = 0; exp_cnt = 0;
  endtask

  // Drives one cycle of stimulus and advances the model across the same edge.
  task automatic step(input bit ce, input bit v, input int a, input int b, input int c, input bit clr);
    item_t it;
    int ya, yb, yc;
    bit f;
    @(negedge clk);
    bus.clk_enable = ce; drv_ce = ce;
    bus.in_valid = v;
    bus.in_a = 16'(a); bus.in_b = 16'(b); bus.in_c = 16'(c);
    bus.sat_clr = clr;
    @(posedge clk);
    if (ce) begin
      e_cnt++;
      exp_valid = 0;
      if (q.size() > 0 && q[0].due == e_cnt) begin
        it = q.pop_front();
        ref_calc(it.a, it.b, it.c, ya, yb, yc, f);
        exp_valid = 1; exp_a = ya; exp_b = yb; exp_c = yc; exp_flag = f;
      end
      if (clr) exp_cnt = 0;
      else if (exp_valid && exp_flag && exp_cnt < 65535) exp_cnt++;
      if (v) begin
        it.a = a; it.b = b; it.c = c; it.due = e_cnt + 3;
        q.push_back(it);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.clk_enable = 1'b1; drv_ce = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.sat_clr = 1'b0;
    model_reset();
    e_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", got_vec(), exp_vec());
    end
    bus.clk_enable = 1'b0;
    #1;
    checks++;
    if (bus.ce_out !== 1'b0) begin
      failures++;
      $display("FAIL ce_out_low: got %b want 0", bus.ce_out);
    end
    bus.clk_enable = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    int ta[3], tb2[3], tc[3], ea[3], eb[3], ec[3], ef[3];
    ta  = '{1000, 0, 32767};  tb2 = '{-500, 27713, -32768}; tc = '{-500, -27713, 0};
    ea  = '{750, 0, 32767};   eb  = '{-750, 27713, -32767}; ec = '{-750, -27713, 1};
    ef  = '{0, 0, 1};
    step(1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, ta[k], tb2[k], tc[k], 0);
      for (int j = 1; j <= 4; j++) begin
        step(1, 0, rnd16(), rnd16(), rnd16(), 0);
        checks++;
        if (got_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL directed_model k=%0d j=%0d: got %h want %h", k, j, got_vec(), exp_vec());
        end
        checks++;
        if (bus.out_valid !== (j == 3)) begin
          failures++;
          $display("FAIL directed_latency k=%0d j=%0d: got %b want %b", k, j, bus.out_valid, (j == 3));
        end
        if (j == 3) begin
          checks++;
          if ({bus.out_a, bus.out_b, bus.out_c, bus.sat_flag} !==
              {16'(ea[k]), 16'(eb[k]), 16'(ec[k]), ef[k][0]}) begin
            failures++;
            $display("FAIL directed_value k=%0d: got %0d %0d %0d f=%b want %0d %0d %0d f=%0d",
                     k, bus.out_a, bus.out_b, bus.out_c, bus.sat_flag, ea[k], eb[k], ec[k], ef[k]);
          end
        end
      end
    end
    checks++;
    if (bus.sat_count !== 16'd1) begin
      failures++;
      $display("FAIL directed_satcount: got %0d want 1", bus.sat_count);
    end
  endtask

  task automatic test_stream_stall();
    int n, cyc, seen;
    bit ce;
    n = 0; cyc = 0; seen = 0;
    while (cyc < 30) begin
      ce = !(cyc >= 4 && cyc < 7);
      step(ce, (n < 10), rnd16(), rnd16(), rnd16(), 0);
      if (ce && n < 10) n++;
      if (ce && bus.out_valid) seen++;
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_stream cyc=%0d: got %h want %h", cyc, got_vec(), exp_vec());
      end
      cyc++;
    end
    checks++;
    if (seen !== 10) begin
      failures++;
      $display("FAIL stall_count: got %0d outputs want 10", seen);
    end
  endtask

  task automatic test_random();
    int a, b, c, p;
    for (int i = 0; i < 300; i++) begin
      a = rnd16(); b = rnd16(); c = rnd16();
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(0, 2);
        a = (p == 0) ? 32767 : (p == 1) ? -32768 : a;
        b = (p == 1) ? 32767 : (p == 2) ? -32768 : b;
        c = (p == 2) ? 32767 : (p == 0) ? -32768 : c;
      end
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, a, b, c, $urandom_range(0, 19) == 0);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random i=%0d: got %h want %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1, 1, rnd16(), rnd16(), rnd16(), 0);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.sat_clr = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL midreset_zero: got %h want %h", got_vec(), exp_vec());
    end
    #1 reset_n = 1'b1;
    step(1, 1, rnd16(), rnd16(), rnd16(), 0);
    for (int j = 1; j <= 4; j++) begin
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if (got_vec() !== exp_vec() || bus.out_valid !== (j == 3)) begin
        failures++;
        $display("FAIL midreset_restart j=%0d: got %h want %h", j, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sat_count();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65534; i++) step(1, 1, 32767, -32768, rnd16(), 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (got_vec() !== exp_vec() || bus.sat_count !== 16'd65534) begin
      failures++;
      $display("FAIL sat_near_max: got %h cnt=%0d want %h cnt=65534", got_vec(), bus.sat_count, exp_vec());
    end
    for (int i = 0; i < 3; i++) step(1, 1, -32768, rnd16(), 32767, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (got_vec() !== exp_vec() || bus.sat_count !== 16'd65535) begin
      failures++;
      $display("FAIL sat_sticky: got %h cnt=%0d want %h cnt=65535", got_vec(), bus.sat_count, exp_vec());
    end
    step(1, 1, 32767, 0, -32768, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    checks++;
    if ({bus.out_valid, bus.sat_flag, bus.sat_count} !== {1'b1, 1'b1, 16'd0} || got_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL sat_clr_wins: got v=%b f=%b cnt=%0d want v=1 f=1 cnt=0",
               bus.out_valid, bus.sat_flag, bus.sat_count);
    end
    step(1, 1, 32767, -32768, 5, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.sat_count !== 16'd1 || got_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL sat_after_clr: got cnt=%0d want 1", bus.sat_count);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_stream_stall();
    test_random();
    test_reset_midstream();
    test_sat_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
